// File: rtl/demux_stream.sv
// Valid/ready stream demultiplexer: routes each accepted beat to one of NUM_CH
// one-entry output slots, or to every slot at once in broadcast mode.
module demux_stream #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [7:0]               drop_cnt
);

    localparam int              SEL_N    = 1 << SEL_W;
    localparam logic [SEL_W:0]  NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    slot_t             slot_r     [NUM_CH];
    slot_t             slot_nxt_s [NUM_CH];
    logic [DATA_W-1:0] data_r     [NUM_CH];
    logic [SEL_N-1:0]  free_s;
    logic [NUM_CH-1:0] load_s;
    logic              sel_ok_s;
    logic              accept_s;
    logic              drop_s;
    logic [7:0]        drop_cnt_r;

    assign sel_ok_s = ({1'b0, in_sel} < NUM_CH_W);
    assign accept_s = in_valid & in_ready;
    assign drop_s   = accept_s & ~in_bcast & ~sel_ok_s;

    // Slot is free when empty or being drained this cycle; unused codes stay 0.
    always_comb begin
        free_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            free_s[k] = (slot_r[k] == SLOT_EMPTY) | out_ready[k];
        end
    end

    // Acceptance: broadcast needs every slot free, out-of-range selects always sink.
    always_comb begin
        in_ready = 1'b0;
        if (in_bcast) begin
            in_ready = &free_s[NUM_CH-1:0];
        end else if (sel_ok_s) begin
            in_ready = free_s[in_sel];
        end else begin
            in_ready = 1'b1;
        end
    end

    // Per-slot load strobes for the accepted beat.
    always_comb begin
        load_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (accept_s && (in_bcast || (sel_ok_s && (in_sel == SEL_W'(k))))) begin
                load_s[k] = 1'b1;
            end else begin
                load_s[k] = 1'b0;
            end
        end
    end

    // Slot FSM next state; a simultaneous drain and load keeps the slot full.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            slot_nxt_s[k] = slot_r[k];
            case (slot_r[k])
                SLOT_EMPTY: begin
                    if (load_s[k]) begin
                        slot_nxt_s[k] = SLOT_FULL;
                    end else begin
                        slot_nxt_s[k] = SLOT_EMPTY;
                    end
                end
                SLOT_FULL: begin
                    if (load_s[k]) begin
                        slot_nxt_s[k] = SLOT_FULL;
                    end else if (out_ready[k]) begin
                        slot_nxt_s[k] = SLOT_EMPTY;
                    end else begin
                        slot_nxt_s[k] = SLOT_FULL;
                    end
                end
                default: slot_nxt_s[k] = SLOT_EMPTY;
            endcase
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                slot_r[k] <= SLOT_EMPTY;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                slot_r[k] <= slot_nxt_s[k];
            end
        end
    end

    // Slot payload register; held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                data_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (load_s[k]) begin
                    data_r[k] <= in_data;
                end
            end
        end
    end

    // Saturating count of beats sunk by out-of-range selects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign out_valid[g]                     = (slot_r[g] == SLOT_FULL);
        assign out_data[g*DATA_W +: DATA_W]     = data_r[g];
    end

    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream: per-channel expected-data queues filled at
// acceptance and drained by an independent output monitor.
module tb_demux_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic [1:0]  in_sel = 2'd0;
    logic        in_bcast = 1'b0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'hF;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;

    logic        d3_valid = 1'b0;
    logic        d3_ready;
    logic [7:0]  d3_data = 8'h00;
    logic [1:0]  d3_sel = 2'd0;
    logic        d3_bcast = 1'b0;
    logic [2:0]  d3_out_valid;
    logic [2:0]  d3_out_ready = 3'b111;
    logic [23:0] d3_out_data;
    logic [7:0]  d3_drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef logic [7:0] byte_q_t[$];
    byte_q_t     exp_q [4];
    logic [3:0]  occ_m = 4'h0;
    logic        hold_m = 1'b0;

    demux_stream #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );

    demux_stream #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(d3_valid), .in_ready(d3_ready),
        .in_data(d3_data), .in_sel(d3_sel), .in_bcast(d3_bcast),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data),
        .drop_cnt(d3_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One producer cycle: drive at posedge+1, then evaluate the reference model at negedge.
    task automatic cycle(input logic v, input logic [1:0] s, input logic b,
                         input logic [7:0] d, input logic [3:0] r);
        logic [3:0] free;
        logic       exp_rdy;
        logic [3:0] load;
        @(posedge clk);
        #1;
        in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ready = r;
        @(negedge clk);
        for (int k = 0; k < 4; k++) free[k] = !occ_m[k] || r[k];
        exp_rdy = b ? (&free) : free[s];
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        hold_m = v && !exp_rdy;
        load = 4'h0;
        if (v && exp_rdy) begin
            for (int k = 0; k < 4; k++) begin
                if (b || (s == 2'(k))) begin
                    exp_q[k].push_back(d);
                    load[k] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 4; k++) occ_m[k] = (occ_m[k] && !r[k]) || load[k];
    endtask

    // Output monitor: every completed handshake must match the oldest expected beat.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    if (out_valid[k] && out_ready[k]) begin
                        n_checks++;
                        if (exp_q[k].size() == 0) begin
                            n_errors++;
                            $display("FAIL unexpected_beat ch%0d: got %0h expected none", k, out_data[k*8 +: 8]);
                        end else begin
                            exp_b = exp_q[k].pop_front();
                            if (out_data[k*8 +: 8] !== exp_b) begin
                                n_errors++;
                                $display("FAIL beat_data ch%0d: got %0h expected %0h", k, out_data[k*8 +: 8], exp_b);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic       v, b;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] r;

        #1;
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Unicast to channel 2, one-cycle latency, then empty.
        cycle(1'b1, 2'd2, 1'b0, 8'hA5, 4'hF);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        chk("t1_valid", {28'd0, out_valid}, 32'h4);
        chk("t1_data", {24'd0, out_data[23:16]}, 32'hA5);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        chk("t1_empty", {28'd0, out_valid}, 32'h0);

        // Backpressure on channel 1, then drain and reload in one cycle.
        cycle(1'b1, 2'd1, 1'b0, 8'h11, 4'b1101);
        cycle(1'b1, 2'd1, 1'b0, 8'h22, 4'b1101);
        chk("t2_stall_valid", {28'd0, out_valid}, 32'h2);
        chk("t2_stall_data", {24'd0, out_data[15:8]}, 32'h11);
        cycle(1'b1, 2'd1, 1'b0, 8'h22, 4'b1111);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
        chk("t2_reload_valid", {28'd0, out_valid}, 32'h2);
        chk("t2_reload_data", {24'd0, out_data[15:8]}, 32'h22);

        // Broadcast, then broadcast blocked by a stalled channel 3.
        cycle(1'b1, 2'd0, 1'b1, 8'h3C, 4'hF);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        chk("t3_bcast_valid", {28'd0, out_valid}, 32'hF);
        chk("t3_bcast_data", out_data, 32'h3C3C3C3C);
        cycle(1'b1, 2'd3, 1'b0, 8'h77, 4'b0111);
        repeat (2) begin
            cycle(1'b1, 2'd1, 1'b1, 8'h5A, 4'b0111);
            chk("t3_stall_valid", {28'd0, out_valid}, 32'h8);
        end
        cycle(1'b1, 2'd1, 1'b1, 8'h5A, 4'hF);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        chk("t3_after_valid", {28'd0, out_valid}, 32'hF);
        chk("t3_after_data", out_data, 32'h5A5A5A5A);

        // Alternating channels at full rate.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 2'(i % 2), 1'b0, 8'(8'h40 + i), 4'hF);
            if (i > 0) chk("t5_alt_valid", {28'd0, out_valid}, 32'(4'b0001 << ((i - 1) % 2)));
        end
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);

        // Randomized traffic with producer hold on stall.
        for (int i = 0; i < 400; i++) begin
            if (!hold_m) begin
                v = ($urandom_range(0, 3) != 0);
                s = 2'($urandom_range(0, 3));
                b = ($urandom_range(0, 7) == 0);
                d = 8'($urandom);
            end
            for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 3) != 0);
            cycle(v, s, b, d, r);
        end
        repeat (3) cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        for (int k = 0; k < 4; k++) chk("drain_empty", exp_q[k].size(), 32'd0);
        chk("drop_cnt_main", {24'd0, drop_cnt}, 32'd0);

        // Out-of-range select on the 3-channel instance: sink and saturate.
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 8'($urandom);
            @(negedge clk);
            chk("t4_ready", {31'd0, d3_ready}, 32'd1);
            chk("t4_no_valid", {29'd0, d3_out_valid}, 32'd0);
            chk("t4_drop_cnt", {24'd0, d3_drop_cnt}, (i - 1 > 255) ? 32'd255 : 32'(i - 1));
        end
        @(posedge clk); #1;
        d3_valid = 1'b0;
        @(negedge clk);
        chk("t4_drop_sat", {24'd0, d3_drop_cnt}, 32'd255);

        // Asynchronous reset with channels 0 and 2 full.
        cycle(1'b1, 2'd0, 1'b0, 8'hD0, 4'b1010);
        cycle(1'b1, 2'd2, 1'b0, 8'hD2, 4'b1010);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'b1010);
        chk("t6_pre_valid", {28'd0, out_valid}, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {28'd0, out_valid}, 32'h0);
        chk("t6_async_drop", {24'd0, d3_drop_cnt}, 32'd0);
        chk("t6_async_data", out_data, 32'd0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        occ_m = 4'h0;
        hold_m = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 2'd2, 1'b0, 8'hE2, 4'hF);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        chk("t6_resume_valid", {28'd0, out_valid}, 32'h4);
        cycle(1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
        for (int k = 0; k < 4; k++) chk("final_empty", exp_q[k].size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
Parametrised successor to the 1-to-4 combinational demultiplexer. Routes a valid/ready input stream to one of NUM_CH output channels selected per beat, or to all channels in broadcast mode. Each channel has a one-entry output register, so one beat per cycle flows without bubbles. Sits between a single producer and NUM_CH independent consumers in the datapath.

Parameters:
DATA_W, 8, payload width in bits.
NUM_CH, 4, number of output channels (2..16).
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_CH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  producer beat valid.
in_ready  output  1  block can accept the beat this cycle (combinational).
in_data  input  DATA_W  payload.
in_sel  input  SEL_W  target channel index.
in_bcast  input  1  1 = deliver the beat to all channels; in_sel is ignored.
out_valid  output  NUM_CH  per-channel valid, bit k = channel k.
out_ready  input  NUM_CH  per-channel consumer ready.
out_data  output  NUM_CH*DATA_W  channel k payload in bits [k*DATA_W +: DATA_W].
drop_cnt  output  8  saturating count of beats dropped for out-of-range select.

Behaviour:
- Reset: asynchronous on rst_n low. out_valid=0, every out_data slice=0, drop_cnt=0, all channel slots EMPTY. in_ready is combinational, so it follows the reset slot state and evaluates to 1 when in_bcast is 0 or in_sel is in range.
- Per-channel slot FSM with states EMPTY and FULL:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on out_valid&out_ready with no load in the same cycle.
  - FULL -> FULL on drain and load in the same cycle; the new data replaces the old.
  - A FULL slot without out_ready holds out_data stable.
- Channel k is "free" when it is EMPTY or draining this cycle (out_ready[k]=1).
- in_ready:
  - unicast, in_sel<NUM_CH: equals free[in_sel].
  - broadcast: AND of free over all channels.
  - unicast, in_sel>=NUM_CH: 1.
- Accept occurs when in_valid & in_ready. Loads on accept:
  - unicast: slot in_sel loads in_data.
  - broadcast: all slots load in_data.
  - out-of-range select: no slot loads; drop_cnt increments and saturates at 255.
- Latency: a beat accepted in cycle N appears on out_valid/out_data in cycle N+1. Sustained throughput is 1 beat/cycle when the target consumer holds out_ready=1.
- Ordering: beats sent to the same channel leave that channel in acceptance order. There is no ordering relation between channels.
- Broadcast is all-or-nothing: no partial delivery. A stall on any one channel stalls the broadcast.
- in_ready depends only on in_sel, in_bcast, out_ready and slot state, never on in_valid. The producer must hold in_data, in_sel and in_bcast stable while in_valid=1 and in_ready=0.
- Reset mid-operation: all pending slot contents are discarded; there is no recovery of in-flight beats.
- Unused select codes (NUM_CH..2**SEL_W-1) are the only drop source.

Test Plan:
1. Reset, then unicast 0xA5 with sel=2, all out_ready=1 -> next cycle out_valid=4'b0100, channel 2 data=0xA5; following cycle out_valid=0.
2. Channel 1 out_ready=0; send 0x11 then 0x22 to sel=1 -> first accepted; second sees in_ready=0 and holds. Raise out_ready[1] -> 0x11 drains, 0x22 is loaded in the same cycle and appears the next cycle; no bubble, no loss.
3. Broadcast 0x3C with out_ready=4'b1111 -> out_valid=4'b1111 one cycle later, all slices=0x3C. Repeat with channel 3 FULL and out_ready[3]=0 -> in_ready=0, no slot loads until channel 3 drains.
4. NUM_CH=3, SEL_W=2, sel=3 on 300 consecutive beats -> in_ready=1 every cycle, out_valid never set, drop_cnt reaches 255 and holds.
5. Back-to-back alternating sel=0/sel=1 beats, consumers always ready -> one beat per cycle on the alternating channels, data order preserved per channel.
6. Assert rst_n low asynchronously while channels 0 and 2 are FULL -> out_valid=0 and drop_cnt=0 immediately, with no clock edge; normal operation resumes on the first edge after release.
